stopwatch_counter: RTL and testbench

Minute:second time-keeping core for the stopwatch display path. Consumes the single-cycle tick pulses from the clock divider and maintains a BCD MM:SS count with pause, clear and per-field adjust. Also produces per-digit blanking for the adjust-mode blink. Outputs feed the seven-segment multiplexer, which scans on the 400 Hz tick.

---
 rtl/stopwatch_counter.sv | 138 +++++++++++++
 tb/tb_stopwatch_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch core with pause/clear, per-field adjust and adjust-mode blink blanking.
// Optional blink blanking is built when STOPWATCH_BLINK_EN is defined; otherwise blank is tied to 0.
module stopwatch_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       one_hz_tick,
    input  logic       two_hz_tick,
    input  logic       blink_tick,
    input  logic       pause_pulse,
    input  logic       clear_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [3:0] blank
);

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic [8:0] sec_inc, min_inc;

    // Returns {carry, tens, ones} for a 00-59 BCD field; out-of-range digits fold back to 0.
    function automatic logic [8:0] inc_field(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] r;
        if (ones >= 4'd9) begin
            if (tens >= 4'd5)
                r = 9'h100;
            else
                r = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            r = {1'b0, tens, ones + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        sec_inc = inc_field(sec_tens_q, sec_ones_q);
        min_inc = inc_field(min_tens_q, min_ones_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PAUSED;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
        end
    end

    // Count decisions use the pre-toggle state, so a tick coinciding with pause_pulse
    // counts only when leaving RUN.
    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;

        if (pause_pulse)
            state_d = (state_q == RUN) ? PAUSED : RUN;

        if (clear_pulse) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (adj) begin
            if (two_hz_tick) begin
                if (sel) begin
                    sec_tens_d = sec_inc[7:4];
                    sec_ones_d = sec_inc[3:0];
                end else begin
                    min_tens_d = min_inc[7:4];
                    min_ones_d = min_inc[3:0];
                end
            end
        end else if (state_q == RUN && one_hz_tick) begin
            sec_tens_d = sec_inc[7:4];
            sec_ones_d = sec_inc[3:0];
            if (sec_inc[8]) begin
                min_tens_d = min_inc[7:4];
                min_ones_d = min_inc[3:0];
            end
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign running  = (state_q == RUN);

`ifdef STOPWATCH_BLINK_EN
    logic       phase_q, phase_d;
    logic [3:0] blank_q, blank_d;

    // Blank is registered from the next phase so it changes on the same edge as the phase.
    always_comb begin
        phase_d = adj ? (phase_q ^ blink_tick) : 1'b0;
        blank_d = 4'b0000;
        if (adj && phase_d)
            blank_d = sel ? 4'b0011 : 4'b1100;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            blank_q <= 4'b0000;
        end else begin
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    logic unused_blink_tick;
    assign unused_blink_tick = blink_tick;
    assign blank             = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard testbench for stopwatch_counter: a seconds-count reference model predicts each
// cycle's outputs, a monitor compares them against the DUT on the falling edge.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       one_hz_tick = 1'b0, two_hz_tick = 1'b0, blink_tick = 1'b0;
    logic       pause_pulse = 1'b0, clear_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic       running;
    logic [20:0] dut_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [20:0] exp_q[$];

    // Reference model state: total elapsed seconds, run flag, blink phase.
    int       m_secs  = 0;
    bit       m_run   = 0;
    bit       m_phase = 0;
    bit [3:0] m_blank = 4'b0000;

    stopwatch_counter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .one_hz_tick(one_hz_tick),
        .two_hz_tick(two_hz_tick),
        .blink_tick (blink_tick),
        .pause_pulse(pause_pulse),
        .clear_pulse(clear_pulse),
        .adj        (adj),
        .sel        (sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    assign dut_out = {min_tens, min_ones, sec_tens, sec_ones, running, blank};

    function automatic logic [20:0] model_outputs();
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_run, m_blank};
    endfunction

    task automatic checkOutput(input string name, input logic [20:0] act, input logic [20:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got mm:ss=%h%h:%h%h run=%b blank=%b, expected mm:ss=%h%h:%h%h run=%b blank=%b",
                     name, act[20:17], act[16:13], act[12:9], act[8:5], act[4], act[3:0],
                     exp_v[20:17], exp_v[16:13], exp_v[12:9], exp_v[8:5], exp_v[4], exp_v[3:0]);
        end
    endtask

    // Drive one cycle of inputs, advance the model for that edge and queue its prediction.
    task automatic applyStimulus(input bit p, input bit c, input bit o, input bit t,
                                 input bit b, input bit a, input bit s);
        int mm, ss;
        pause_pulse = p; clear_pulse = c; one_hz_tick = o;
        two_hz_tick = t; blink_tick = b; adj = a; sel = s;
        @(posedge clk);
        #1;
        mm = m_secs / 60;
        ss = m_secs % 60;
        if (c)
            m_secs = 0;
        else if (a) begin
            if (t) begin
                if (s) m_secs = mm * 60 + (ss + 1) % 60;
                else   m_secs = ((mm + 1) % 60) * 60 + ss;
            end
        end else if (m_run && o)
            m_secs = (m_secs + 1) % 3600;
        if (p) m_run = !m_run;
`ifdef STOPWATCH_BLINK_EN
        m_phase = a ? (m_phase ^ b) : 1'b0;
        m_blank = (a && m_phase) ? (s ? 4'b0011 : 4'b1100) : 4'b0000;
`else
        m_blank = 4'b0000;
`endif
        exp_q.push_back(model_outputs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preload(input int mm, input int ss);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < mm; i++) applyStimulus(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < ss; i++) applyStimulus(0, 0, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic midReset();
        pause_pulse = 0; clear_pulse = 0; one_hz_tick = 0;
        two_hz_tick = 0; blink_tick = 0; adj = 0; sel = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", dut_out, 21'd0);
        m_secs = 0; m_run = 0; m_phase = 0; m_blank = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every predicted cycle is compared once the DUT output has settled.
    always @(negedge clk) begin
        if (exp_q.size() > 0)
            checkOutput("scoreboard", dut_out, exp_q.pop_front());
    end

    initial begin
        bit a_lvl, s_lvl;
        #1;
        checkOutput("reset_state", dut_out, 21'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ticks while paused must not count; then run 61 s.
        for (int i = 0; i < 61; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("run_61s", dut_out, {4'd0, 4'd1, 4'd0, 4'd1, 1'b1, 4'b0000});

        // Full wrap 59:59 -> 00:00.
        preload(59, 58);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("wrap_5959", dut_out, {4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0000});

        // Seconds adjust wraps without touching minutes; one_hz ignored in adjust.
        preload(0, 58);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 1, 1);
        checkOutput("adjust_sec_wrap", dut_out[20:5], {4'd0, 4'd0, 4'd0, 4'd1});

        // Pause and tick together while running: tick counts.
        preload(0, 10);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("pause_with_tick", dut_out, {4'd0, 4'd0, 4'd1, 4'd1, 1'b0, 4'b0000});
        // Resume together with a tick: tick does not count.
        applyStimulus(1, 0, 1, 0, 0, 0, 0);

        // Clear beats a simultaneous tick.
        preload(12, 34);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        midReset();

        // Blink phase sequence in minutes and seconds adjust.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic, with level inputs changing occasionally.
        a_lvl = 0; s_lvl = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(99) == 0) a_lvl = !a_lvl;
            if ($urandom_range(19) == 0) s_lvl = !s_lvl;
            applyStimulus($urandom_range(39) == 0, $urandom_range(799) == 0,
                          $urandom_range(1) == 0, $urandom_range(2) == 0,
                          $urandom_range(3) == 0, a_lvl, s_lvl);
            if (i == 3000) midReset();
        end

        idle(2);
        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
